dircc_avalon_st_packet_port: RTL and testbench



---
 rtl/dircc_types_pkg.sv | 39 +++
 rtl/dircc_avalon_st_rx.sv | 112 +++++++++++
 rtl/dircc_avalon_st_tx.sv | 86 ++++++++
 rtl/dircc_avalon_st_packet_port.sv | 74 +++++++
 tb/tb_dircc_avalon_st_packet_port.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dircc_types_pkg.sv
// Shared DiRCC packet types and the FSM state encodings used by the Avalon-ST packet port.
// Also holds small sizing helpers for beat and empty-field widths.
package dircc_types_pkg;

  typedef logic [31:0] lamport_t;

  typedef struct packed {
    logic [15:0] hw_addr;
    logic [7:0]  sw_addr;
    logic [6:0]  port;
    logic        flag;
  } address_t;

  typedef struct packed {
    address_t    dest_addr;
    address_t    src_addr;
    lamport_t    lamport;
    logic [31:0] data;
  } packet_t;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/dircc_avalon_st_rx.sv
// Avalon-ST deserializer: gathers MSB-first beats into one packet and publishes it
// only when the eop arrives on exactly the last expected beat.
module dircc_avalon_st_rx
  import dircc_types_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 4,
  parameter int PACKET_WIDTH     = $bits(packet_t),
  localparam int DATA_WIDTH      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  localparam int EMPTY_WIDTH     = max1($clog2(SYMBOLS_PER_BEAT))
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    booting,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [EMPTY_WIDTH-1:0]  in_empty,
  input  logic                    in_startofpacket,
  input  logic                    in_endofpacket,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [PACKET_WIDTH-1:0] packet_data,
  output logic                    packet_valid,
  output logic                    receive_nearly_done,
  output logic                    receive_done
);

  localparam int NBEATS   = ceil_div(PACKET_WIDTH, DATA_WIDTH);
  localparam int PADDED_W = NBEATS * DATA_WIDTH;
  localparam int PAD_W    = PADDED_W - PACKET_WIDTH;
  localparam int CNT_W    = max1($clog2(NBEATS + 1));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NBEATS);

  rx_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PADDED_W-1:0]     buf_q, buf_d;
  logic [PACKET_WIDTH-1:0] pdata_q, pdata_d;
  logic                    pvalid_q, pvalid_d;
  logic                    done_q;
  logic                    accept;
  logic                    complete;
  logic                    unused_empty;

  // Empty is implied by the fixed packet size, so the incoming field is not needed.
  assign unused_empty = ^in_empty;

  assign in_ready = !reset && !booting;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    pdata_d  = pdata_q;
    pvalid_d = pvalid_q;
    complete = 1'b0;
    if (accept) begin
      if (in_startofpacket) begin
        buf_d    = PADDED_W'(in_data);
        pvalid_d = 1'b0;
        if (in_endofpacket) begin
          complete = (NBEATS == 1);
          state_d  = RX_IDLE;
          cnt_d    = '0;
        end else begin
          state_d = RX_RECV;
          cnt_d   = CNT_W'(1);
        end
      end else if (state_q == RX_RECV) begin
        // Beats past the end are dropped; the counter parks at FULL_CNT.
        if (cnt_q != FULL_CNT) begin
          buf_d = (buf_q << DATA_WIDTH) | PADDED_W'(in_data);
        end
        if (in_endofpacket) begin
          complete = (cnt_q == LAST_CNT);
          state_d  = RX_IDLE;
          cnt_d    = '0;
        end else if (cnt_q != FULL_CNT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
    if (complete) begin
      pdata_d  = PACKET_WIDTH'(buf_d >> PAD_W);
      pvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      buf_q    <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      done_q   <= complete;
    end
  end

  assign packet_data         = pdata_q;
  assign packet_valid        = pvalid_q;
  assign receive_nearly_done = complete;
  assign receive_done        = done_q;

endmodule

// File: rtl/dircc_avalon_st_tx.sv
// Avalon-ST serializer: latches one packet and streams it MSB-first, holding
// the current beat stable while the sink stalls.
module dircc_avalon_st_tx
  import dircc_types_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 4,
  parameter int PACKET_WIDTH     = $bits(packet_t),
  localparam int DATA_WIDTH      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  localparam int EMPTY_WIDTH     = max1($clog2(SYMBOLS_PER_BEAT))
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_packet,
  input  logic [PACKET_WIDTH-1:0] tx_packet,
  output logic                    sending,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [EMPTY_WIDTH-1:0]  out_empty,
  output logic                    out_startofpacket,
  output logic                    out_endofpacket,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int NBEATS   = ceil_div(PACKET_WIDTH, DATA_WIDTH);
  localparam int PADDED_W = NBEATS * DATA_WIDTH;
  localparam int PAD_W    = PADDED_W - PACKET_WIDTH;
  localparam int BEAT_W   = max1($clog2(NBEATS));
  localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [EMPTY_WIDTH-1:0] EMPTY_VAL = EMPTY_WIDTH'(PAD_W / BITS_PER_SYMBOL);

  tx_state_e           state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [PADDED_W-1:0] pkt_q, pkt_d;
  logic                busy;

  assign busy = (state_q == TX_SEND);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    case (state_q)
      TX_IDLE: begin
        if (write_packet) begin
          // Left-justify so the short tail beat is zero-padded at the bottom.
          pkt_d   = PADDED_W'(tx_packet) << PAD_W;
          beat_d  = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (out_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = TX_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            pkt_d  = pkt_q << DATA_WIDTH;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      beat_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
    end
  end

  assign sending           = busy;
  assign out_valid         = busy;
  assign out_data          = busy ? pkt_q[PADDED_W-1 -: DATA_WIDTH] : '0;
  assign out_startofpacket = busy && (beat_q == '0);
  assign out_endofpacket   = busy && (beat_q == LAST_BEAT);
  assign out_empty         = out_endofpacket ? EMPTY_VAL : '0;

endmodule

// File: rtl/dircc_avalon_st_packet_port.sv
// DiRCC processing-element packet port: independent Avalon-ST receive and
// transmit paths between the router and the core.
module dircc_avalon_st_packet_port
  import dircc_types_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 4,
  parameter int PACKET_WIDTH     = $bits(packet_t),
  localparam int DATA_WIDTH      = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  localparam int EMPTY_WIDTH     = max1($clog2(SYMBOLS_PER_BEAT))
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    booting,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [EMPTY_WIDTH-1:0]  in_empty,
  input  logic                    in_startofpacket,
  input  logic                    in_endofpacket,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [PACKET_WIDTH-1:0] packet_data,
  output logic                    packet_valid,
  output logic                    receive_nearly_done,
  output logic                    receive_done,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [EMPTY_WIDTH-1:0]  out_empty,
  output logic                    out_startofpacket,
  output logic                    out_endofpacket,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    write_packet,
  input  logic [PACKET_WIDTH-1:0] tx_packet,
  output logic                    sending
);

  dircc_avalon_st_rx #(
    .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
    .SYMBOLS_PER_BEAT(SYMBOLS_PER_BEAT),
    .PACKET_WIDTH    (PACKET_WIDTH)
  ) u_rx (
    .clk                (clk),
    .reset              (reset),
    .booting            (booting),
    .in_data            (in_data),
    .in_empty           (in_empty),
    .in_startofpacket   (in_startofpacket),
    .in_endofpacket     (in_endofpacket),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .packet_data        (packet_data),
    .packet_valid       (packet_valid),
    .receive_nearly_done(receive_nearly_done),
    .receive_done       (receive_done)
  );

  dircc_avalon_st_tx #(
    .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
    .SYMBOLS_PER_BEAT(SYMBOLS_PER_BEAT),
    .PACKET_WIDTH    (PACKET_WIDTH)
  ) u_tx (
    .clk              (clk),
    .reset            (reset),
    .write_packet     (write_packet),
    .tx_packet        (tx_packet),
    .sending          (sending),
    .out_data         (out_data),
    .out_empty        (out_empty),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket  (out_endofpacket),
    .out_valid        (out_valid),
    .out_ready        (out_ready)
  );

endmodule

// File: tb/tb_dircc_avalon_st_packet_port.sv
// Directed and loopback bench for the DiRCC Avalon-ST packet port with
// scoreboards for received packets and transmitted beats.
module tb_dircc_avalon_st_packet_port;

  localparam int DW = 32;
  localparam int PW = 128;
  localparam int NB = 4;
  localparam int EW = 2;

  logic          clk;
  logic          reset;
  logic          booting;
  logic [DW-1:0] tb_in_data;
  logic [EW-1:0] tb_in_empty;
  logic          tb_in_sop;
  logic          tb_in_eop;
  logic          tb_in_valid;
  logic          tb_out_ready;
  logic          lb;
  logic          gate;
  logic          write_packet;
  logic [PW-1:0] tx_packet;

  logic [DW-1:0] in_data;
  logic [EW-1:0] in_empty;
  logic          in_startofpacket;
  logic          in_endofpacket;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] packet_data;
  logic          packet_valid;
  logic          receive_nearly_done;
  logic          receive_done;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_empty;
  logic          out_startofpacket;
  logic          out_endofpacket;
  logic          out_valid;
  logic          out_ready;
  logic          sending;

  // Loopback feeds TX straight into RX; gate throttles both sides of the same transfer.
  assign in_data          = lb ? out_data : tb_in_data;
  assign in_empty         = lb ? out_empty : tb_in_empty;
  assign in_startofpacket = lb ? out_startofpacket : tb_in_sop;
  assign in_endofpacket   = lb ? out_endofpacket : tb_in_eop;
  assign in_valid         = lb ? (out_valid & gate) : tb_in_valid;
  assign out_ready        = lb ? (in_ready & gate) : tb_out_ready;

  dircc_avalon_st_packet_port dut (
    .clk                (clk),
    .reset              (reset),
    .booting            (booting),
    .in_data            (in_data),
    .in_empty           (in_empty),
    .in_startofpacket   (in_startofpacket),
    .in_endofpacket     (in_endofpacket),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .packet_data        (packet_data),
    .packet_valid       (packet_valid),
    .receive_nearly_done(receive_nearly_done),
    .receive_done       (receive_done),
    .out_data           (out_data),
    .out_empty          (out_empty),
    .out_startofpacket  (out_startofpacket),
    .out_endofpacket    (out_endofpacket),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .write_packet       (write_packet),
    .tx_packet          (tx_packet),
    .sending            (sending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] rx_q[$];
  logic [35:0]   tx_q[$];

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_tx(input logic [PW-1:0] p);
    for (int k = 0; k < NB; k++) begin
      tx_q.push_back({p[PW-1-k*DW -: DW], (k == 0), (k == NB - 1), 2'b00});
    end
  endfunction

  always @(posedge clk) begin
    #1;
    gate = ($urandom_range(0, 3) != 0);
  end

  logic [35:0]   mon_tx_exp;
  logic [PW-1:0] mon_rx_exp;
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        check("tx_beat_expected", (tx_q.size() != 0), 1);
        if (tx_q.size() != 0) begin
          mon_tx_exp = tx_q.pop_front();
          check("tx_beat", {out_data, out_startofpacket, out_endofpacket, out_empty}, mon_tx_exp);
        end
      end
      if (receive_done) begin
        check("rx_done_expected", (rx_q.size() != 0), 1);
        if (rx_q.size() != 0) begin
          mon_rx_exp = rx_q.pop_front();
          check("rx_packet", packet_data, mon_rx_exp);
          check("rx_valid_with_done", packet_valid, 1);
        end
      end
    end
  end

  task automatic rx_beat(input logic [DW-1:0] d, input logic sop, input logic eop, input logic exp_nd);
    tb_in_data  = d;
    tb_in_sop   = sop;
    tb_in_eop   = eop;
    tb_in_valid = 1'b1;
    #1;
    check("rx_nearly_done", receive_nearly_done, exp_nd);
    @(posedge clk);
    #1;
    tb_in_valid = 1'b0;
    tb_in_sop   = 1'b0;
    tb_in_eop   = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  logic [PW-1:0] pkt;
  logic [DW-1:0] held;
  logic          prev_ready;
  logic [3:0]    bp_pat;
  int            cnt;
  int            w;
  int            idle;

  initial begin
    reset = 1'b1; booting = 1'b0; lb = 1'b0; gate = 1'b0;
    tb_in_data = '0; tb_in_empty = '0; tb_in_sop = 1'b0; tb_in_eop = 1'b0; tb_in_valid = 1'b0;
    tb_out_ready = 1'b0; write_packet = 1'b0; tx_packet = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sending", sending, 0);
    check("rst_packet_valid", packet_valid, 0);
    check("rst_receive_done", receive_done, 0);
    check("rst_packet_data", packet_data, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // RX happy path
    rx_q.push_back(128'h0000000A_0000000B_0000000C_0000000D);
    rx_beat(32'hA, 1, 0, 0);
    rx_beat(32'hB, 0, 0, 0);
    rx_beat(32'hC, 0, 0, 0);
    rx_beat(32'hD, 0, 1, 1);
    check("happy_done", receive_done, 1);
    check("happy_valid", packet_valid, 1);
    check("happy_data", packet_data, 128'h0000000A_0000000B_0000000C_0000000D);
    @(posedge clk);
    #1;
    check("happy_done_pulse", receive_done, 0);
    check("happy_valid_held", packet_valid, 1);

    // booting stalls RX
    booting = 1'b1;
    tb_in_data = 32'h99; tb_in_sop = 1'b1; tb_in_valid = 1'b1;
    #1;
    check("booting_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("booting_valid_kept", packet_valid, 1);
    tb_in_valid = 1'b0; tb_in_sop = 1'b0;
    booting = 1'b0;
    rx_q.push_back(128'h00000001_00000002_00000003_00000004);
    rx_beat(32'h1, 1, 0, 0);
    rx_beat(32'h2, 0, 0, 0);
    rx_beat(32'h3, 0, 0, 0);
    rx_beat(32'h4, 0, 1, 1);
    check("boot_pkt_done", receive_done, 1);

    // short packet
    rx_beat(32'h5, 1, 0, 0);
    rx_beat(32'h6, 0, 1, 0);
    check("short_done", receive_done, 0);
    check("short_valid", packet_valid, 0);
    @(posedge clk);
    #1;
    check("short_done_late", receive_done, 0);

    // restart on fresh sop
    rx_q.push_back(128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3);
    rx_beat(32'hE1, 1, 0, 0);
    rx_beat(32'hE2, 0, 0, 0);
    rx_beat(32'hC0C0C0C0, 1, 0, 0);
    rx_beat(32'hC1C1C1C1, 0, 0, 0);
    rx_beat(32'hC2C2C2C2, 0, 0, 0);
    rx_beat(32'hC3C3C3C3, 0, 1, 1);
    check("restart_done", receive_done, 1);

    // long packet
    rx_beat(32'h71, 1, 0, 0);
    rx_beat(32'h72, 0, 0, 0);
    rx_beat(32'h73, 0, 0, 0);
    rx_beat(32'h74, 0, 0, 0);
    rx_beat(32'h75, 0, 1, 0);
    check("long_valid", packet_valid, 0);
    check("long_done", receive_done, 0);

    // TX straight run
    tb_out_ready = 1'b1;
    pkt = 128'h11111111_22222222_33333333_44444444;
    tx_packet = pkt;
    push_tx(pkt);
    write_packet = 1'b1;
    @(posedge clk);
    #1;
    write_packet = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (sending) cnt++;
      @(posedge clk);
      #1;
    end
    check("tx_sending_cycles", cnt, 4);
    check("tx_q_drained", tx_q.size(), 0);

    // TX backpressure
    bp_pat = 4'b1001;
    pkt = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    tx_packet = pkt;
    push_tx(pkt);
    write_packet = 1'b1;
    @(posedge clk);
    #1;
    write_packet = 1'b0;
    prev_ready = 1'b1;
    held = '0;
    w = 0;
    while (sending && w < 30) begin
      tb_out_ready = bp_pat[w % 4];
      write_packet = (w == 2);
      if (w == 2) tx_packet = 128'h5555;
      if (!prev_ready) check("tx_hold_data", out_data, held);
      held = out_data;
      prev_ready = tb_out_ready;
      @(posedge clk);
      #1;
      w++;
    end
    write_packet = 1'b0;
    tb_out_ready = 1'b1;
    check("tx_bp_finished", sending, 0);
    @(posedge clk);
    #1;
    check("tx_ignored_write", out_valid, 0);
    check("tx_bp_q_drained", tx_q.size(), 0);

    // loopback with random gaps
    lb = 1'b1;
    for (int n = 0; n < 100; n++) begin
      w = 0;
      while (sending && w < 200) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (w >= 200) check("lb_tx_idle_timeout", sending, 0);
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) begin
        @(posedge clk);
        #1;
      end
      pkt = {$urandom, $urandom, $urandom, $urandom};
      tx_packet = pkt;
      push_tx(pkt);
      rx_q.push_back(pkt);
      write_packet = 1'b1;
      @(posedge clk);
      #1;
      write_packet = 1'b0;
    end
    w = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0) && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("lb_rx_q_empty", rx_q.size(), 0);
    check("lb_tx_q_empty", tx_q.size(), 0);
    check("lb_valid_final", packet_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
